bit_diff_gen_fsmd: RTL and testbench

//  Inverse of the bit-difference counter. Given a signed target difference
//  (count of 1s minus count of 0s), serially builds a WIDTH-bit word with

---
 rtl/bit_diff_pkg.sv | 20 ++
 rtl/bit_diff_gen_fsmd.sv | 127 ++++++++++++
 tb/tb_bit_diff_gen_fsmd.sv | 264 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/bit_diff_pkg.sv
// rtl/bit_diff_pkg.sv - shared types and helpers for the bit-difference blocks
//
// Purpose: state encoding and the signed-diff width helper used by both the
// bit-difference counter and the bit-difference generator.
// Ports: none (package).

package bit_diff_pkg;

  typedef enum logic [1:0] {
    START,
    COMPUTE,
    RESTART
  } state_t;

  // Width of a signed value that spans -w..+w.
  function automatic int diff_width(input int w);
    return $clog2(2 * w + 1);
  endfunction

endpackage

// File: rtl/bit_diff_gen_fsmd.sv
// rtl/bit_diff_gen_fsmd.sv - serial generator of a word with a given (ones - zeros) difference
//
// Purpose: given a signed target difference (count of 1s minus count of 0s),
// serially builds a WIDTH-bit word with exactly that difference, 1s packed
// into the LSBs. Uses the go/done handshake of the bit-difference counter.
// Ports:
//   clk      in   1      clock
//   rst      in   1      synchronous active-high reset
//   go       in   1      start request, sampled in START/RESTART
//   diff     in   DW     signed target difference, sampled with go
//   data     out  WIDTH  generated word (registered)
//   invalid  out  1      last request was unrealisable (registered)
//   done     out  1      result valid, high while in RESTART

module bit_diff_gen_fsmd
  import bit_diff_pkg::*;
#(
  parameter int WIDTH = 8,
  localparam int DW = diff_width(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             go,
  input  logic [DW-1:0]    diff,
  output logic [WIDTH-1:0] data,
  output logic             invalid,
  output logic             done
);

  localparam int CW = $clog2(WIDTH);
  localparam int ZW = $clog2(WIDTH + 1);
  // One extra bit so +-WIDTH and the sums stay in range.
  localparam int SW = DW + 1;
  localparam logic signed [SW-1:0] W_S = SW'(WIDTH);

  state_t             state_r, state_n;
  logic [CW-1:0]      count_r, count_n;
  logic [ZW-1:0]      zeros_r, zeros_n;
  // Only the low WIDTH-1 bits of the partial word survive the next shift.
  logic [WIDTH-2:0]   gen_r, gen_n;
  logic [WIDTH-1:0]   data_r, data_n;
  logic               invalid_r, invalid_n;
  // Set when an invalid request arrives in RESTART: forces one START cycle
  // so done visibly drops before the new (invalid) result is flagged.
  logic               bounce_r, bounce_n;

  logic signed [SW-1:0] d_ext;
  logic                 req_valid;
  logic [ZW-1:0]        zeros_load;
  logic [WIDTH-1:0]     shifted;

  always_comb begin
    d_ext      = {diff[DW-1], diff};
    // (WIDTH + diff) even is the same as matching LSBs.
    req_valid  = (d_ext >= -W_S) && (d_ext <= W_S) && (d_ext[0] == W_S[0]);
    zeros_load = ZW'((W_S - d_ext) >>> 1);
    // Zeros go in first so the 1s end up in the LSBs.
    shifted    = {gen_r, (zeros_r == '0)};

    state_n   = state_r;
    count_n   = count_r;
    zeros_n   = zeros_r;
    gen_n     = gen_r;
    data_n    = data_r;
    invalid_n = invalid_r;
    bounce_n  = bounce_r;

    case (state_r)
      START, RESTART: begin
        if (state_r == START && bounce_r) begin
          bounce_n = 1'b0;
          state_n  = RESTART;
        end else if (go) begin
          count_n = '0;
          zeros_n = zeros_load;
          gen_n   = '0;
          if (req_valid) begin
            state_n = COMPUTE;
          end else begin
            data_n    = '0;
            invalid_n = 1'b1;
            bounce_n  = (state_r == RESTART);
            state_n   = (state_r == RESTART) ? START : RESTART;
          end
        end
      end
      COMPUTE: begin
        gen_n   = shifted[WIDTH-2:0];
        count_n = count_r + CW'(1);
        if (zeros_r != '0) begin
          zeros_n = zeros_r - ZW'(1);
        end
        if (count_r == CW'(WIDTH - 1)) begin
          data_n    = shifted;
          invalid_n = 1'b0;
          state_n   = RESTART;
        end
      end
      default: state_n = START;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_r   <= START;
      count_r   <= '0;
      zeros_r   <= '0;
      gen_r     <= '0;
      data_r    <= '0;
      invalid_r <= 1'b0;
      bounce_r  <= 1'b0;
    end else begin
      state_r   <= state_n;
      count_r   <= count_n;
      zeros_r   <= zeros_n;
      gen_r     <= gen_n;
      data_r    <= data_n;
      invalid_r <= invalid_n;
      bounce_r  <= bounce_n;
    end
  end

  assign data    = data_r;
  assign invalid = invalid_r;
  assign done    = (state_r == RESTART);

endmodule

// File: tb/tb_bit_diff_gen_fsmd.sv
// tb/tb_bit_diff_gen_fsmd.sv - self-checking bench for bit_diff_gen_fsmd

module tb_bit_diff_gen_fsmd;
  import bit_diff_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic        go_a   [4];
  logic [5:0]  diff_a [4];
  logic [15:0] data_a [4];
  logic        done_a [4];
  logic        inv_a  [4];

  int checks = 0;
  int errors = 0;

  for (genvar g = 0; g < 4; g++) begin : g_dut
    localparam int W   = (g == 0) ? 8 : (g == 1) ? 2 : (g == 2) ? 5 : 16;
    localparam int DWL = diff_width(W);
    logic [W-1:0] data_w;
    logic         done_w;
    logic         inv_w;
    bit_diff_gen_fsmd #(.WIDTH(W)) dut (
      .clk     (clk),
      .rst     (rst),
      .go      (go_a[g]),
      .diff    (diff_a[g][DWL-1:0]),
      .data    (data_w),
      .invalid (inv_w),
      .done    (done_w)
    );
    assign data_a[g] = 16'(data_w);
    assign done_a[g] = done_w;
    assign inv_a[g]  = inv_w;
  end

  function automatic int wof(input int g);
    case (g)
      0: return 8;
      1: return 2;
      2: return 5;
      default: return 16;
    endcase
  endfunction

  // Reference: a word of width w with (ones - zeros) == d has (w+d)/2 ones in the LSBs.
  function automatic logic [15:0] exp_word(input int w, input int d);
    int ones;
    ones = (w + d) / 2;
    return 16'((32'd1 << ones) - 1);
  endfunction

  function automatic bit exp_valid(input int w, input int d);
    return (d >= -w) && (d <= w) && (((w + d) % 2) == 0);
  endfunction

  function automatic int ones_minus_zeros(input logic [15:0] v, input int w);
    int ones;
    ones = 0;
    for (int i = 0; i < w; i++) ones += int'(v[i]);
    return 2 * ones - w;
  endfunction

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  // Drive go for one cycle (or keep it if hold) and count cycles to done; lat=-1 on timeout.
  task automatic issue(input int g, input int d, input bit hold, input int limit, output int lat);
    lat = -1;
    diff_a[g] = 6'(d);
    go_a[g] = 1'b1;
    for (int j = 1; j <= limit; j++) begin
      tick();
      if (!hold) go_a[g] = 1'b0;
      if (done_a[g]) begin
        lat = j;
        break;
      end
    end
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if (done_a[0] !== 1'b0) begin errors++; $display("FAIL reset_done got %0b want 0", done_a[0]); end
    checks++;
    if (data_a[0] !== 16'h0) begin errors++; $display("FAIL reset_data got %h want 0", data_a[0]); end
    checks++;
    if (inv_a[0] !== 1'b0) begin errors++; $display("FAIL reset_invalid got %0b want 0", inv_a[0]); end
    tick(); tick();
    checks++;
    if (done_a[0] !== 1'b0) begin errors++; $display("FAIL idle_done got %0b want 0", done_a[0]); end
  endtask

  task automatic test_basic();
    int lat;
    issue(0, 2, 1'b0, 30, lat);
    checks++;
    if (lat != 9) begin errors++; $display("FAIL basic_latency got %0d want 9", lat); end
    checks++;
    if (data_a[0] !== 16'h001F) begin errors++; $display("FAIL basic_data got %h want 001f", data_a[0]); end
    checks++;
    if (inv_a[0] !== 1'b0) begin errors++; $display("FAIL basic_invalid got %0b want 0", inv_a[0]); end
  endtask

  task automatic test_boundaries();
    int ds[3];
    logic [15:0] es[3];
    int lat;
    ds = '{8, -8, 0};
    es = '{16'h00FF, 16'h0000, 16'h000F};
    for (int i = 0; i < 3; i++) begin
      issue(0, ds[i], 1'b0, 30, lat);
      checks++;
      if (lat != 9) begin errors++; $display("FAIL bound_latency diff %0d got %0d want 9", ds[i], lat); end
      checks++;
      if (data_a[0] !== es[i]) begin errors++; $display("FAIL bound_data diff %0d got %h want %h", ds[i], data_a[0], es[i]); end
      checks++;
      if (inv_a[0] !== 1'b0) begin errors++; $display("FAIL bound_invalid diff %0d got %0b want 0", ds[i], inv_a[0]); end
    end
  endtask

  task automatic test_invalid();
    int lat;
    do_reset();
    issue(0, 3, 1'b0, 10, lat);
    checks++;
    if (lat != 1) begin errors++; $display("FAIL inv_start_latency got %0d want 1", lat); end
    checks++;
    if (inv_a[0] !== 1'b1) begin errors++; $display("FAIL inv_start_flag got %0b want 1", inv_a[0]); end
    checks++;
    if (data_a[0] !== 16'h0) begin errors++; $display("FAIL inv_start_data got %h want 0", data_a[0]); end
    issue(0, 2, 1'b0, 30, lat);
    checks++;
    if (data_a[0] !== 16'h001F || inv_a[0] !== 1'b0) begin
      errors++; $display("FAIL inv_recover got %h/%0b want 001f/0", data_a[0], inv_a[0]);
    end
    // From RESTART: done stays high in the go cycle, drops for one cycle, returns.
    diff_a[0] = 6'(9);
    go_a[0] = 1'b1;
    checks++;
    if (done_a[0] !== 1'b1) begin errors++; $display("FAIL inv_restart_go_done got %0b want 1", done_a[0]); end
    tick();
    go_a[0] = 1'b0;
    checks++;
    if (done_a[0] !== 1'b0) begin errors++; $display("FAIL inv_restart_drop got %0b want 0", done_a[0]); end
    checks++;
    if (inv_a[0] !== 1'b1 || data_a[0] !== 16'h0) begin
      errors++; $display("FAIL inv_restart_result got %h/%0b want 0000/1", data_a[0], inv_a[0]);
    end
    tick();
    checks++;
    if (done_a[0] !== 1'b1) begin errors++; $display("FAIL inv_restart_return got %0b want 1", done_a[0]); end
  endtask

  task automatic test_back_to_back();
    int ds[3];
    logic [15:0] es[3];
    int lat;
    ds = '{-2, 4, -6};
    es = '{16'h0007, 16'h003F, 16'h0001};
    for (int i = 0; i < 3; i++) begin
      issue(0, ds[i], 1'b1, 30, lat);
      checks++;
      if (lat != 9) begin errors++; $display("FAIL b2b_period op %0d got %0d want 9", i, lat); end
      checks++;
      if (data_a[0] !== es[i]) begin errors++; $display("FAIL b2b_data op %0d got %h want %h", i, data_a[0], es[i]); end
    end
    tick();
    checks++;
    if (done_a[0] !== 1'b0) begin errors++; $display("FAIL b2b_done_width got %0b want 0", done_a[0]); end
    go_a[0] = 1'b0;
    lat = -1;
    for (int j = 0; j < 20; j++) begin
      if (done_a[0]) begin lat = j; break; end
      tick();
    end
    checks++;
    if (lat < 0) begin errors++; $display("FAIL b2b_drain got timeout want done"); end
  endtask

  task automatic test_reset_mid();
    int lat;
    int seen;
    issue(0, 2, 1'b0, 4, lat);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++;
    if (data_a[0] !== 16'h0 || inv_a[0] !== 1'b0 || done_a[0] !== 1'b0) begin
      errors++; $display("FAIL mid_reset got %h/%0b/%0b want 0000/0/0", data_a[0], inv_a[0], done_a[0]);
    end
    seen = 0;
    for (int j = 0; j < 12; j++) begin
      tick();
      if (done_a[0]) seen++;
    end
    checks++;
    if (seen != 0) begin errors++; $display("FAIL mid_reset_no_done got %0d want 0", seen); end
    issue(0, 2, 1'b0, 30, lat);
    checks++;
    if (lat != 9 || data_a[0] !== 16'h001F) begin
      errors++; $display("FAIL mid_reset_after got lat %0d data %h want 9/001f", lat, data_a[0]);
    end
  endtask

  task automatic test_random();
    int w, d, lat;
    for (int g = 0; g < 4; g++) begin
      w = wof(g);
      for (int t = 0; t < 250; t++) begin
        if ($urandom_range(0, 7) == 0) begin
          d = int'($urandom_range(0, 2 * w + 2)) - (w + 1);
        end else begin
          d = 2 * int'($urandom_range(0, w)) - w;
        end
        issue(g, d, 1'b0, w + 10, lat);
        checks++;
        if (exp_valid(w, d)) begin
          if (lat != w + 1 || inv_a[g] !== 1'b0 || ones_minus_zeros(data_a[g], w) != d
              || data_a[g] !== exp_word(w, d)) begin
            errors++;
            $display("FAIL rand_valid w %0d diff %0d got lat %0d data %h inv %0b want lat %0d data %h inv 0",
                     w, d, lat, data_a[g], inv_a[g], w + 1, exp_word(w, d));
          end
        end else begin
          if (lat < 1 || lat > 2 || inv_a[g] !== 1'b1 || data_a[g] !== 16'h0) begin
            errors++;
            $display("FAIL rand_invalid w %0d diff %0d got lat %0d data %h inv %0b want data 0000 inv 1",
                     w, d, lat, data_a[g], inv_a[g]);
          end
        end
      end
    end
  endtask

  initial begin
    rst = 1'b1;
    for (int g = 0; g < 4; g++) begin
      go_a[g] = 1'b0;
      diff_a[g] = '0;
    end
    test_reset();
    test_basic();
    test_boundaries();
    test_invalid();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
